// File: rtl/step_ramp_generator.sv
`default_nettype none
// ============================================================================
// Module   : step_ramp_generator
// Function : Avalon-MM step/direction pulse generator with a trapezoidal ramp
//            profile, signed position counter and move-done interrupt.
// Revision : 1.0
// ============================================================================
module step_ramp_generator #(
  parameter int PULSE_W = 4
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_read,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  output logic        step,
  output logic        forward_back,
  output logic        on_off,
  output logic        irq
);

  localparam logic [31:0] c_P_FLOOR = 32'(2 * PULSE_W);
  localparam logic [31:0] c_PULSE_W = 32'(PULSE_W);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCEL  = 2'd1;
  localparam logic [1:0] c_CRUISE = 2'd2;
  localparam logic [1:0] c_DECEL  = 2'd3;

  // Programming registers
  logic        r_dir, r_enable, r_irq_en;
  logic [31:0] r_target, r_p_start, r_p_min, r_p_dec;
  // Move parameters frozen at START
  logic [31:0] r_sh_p_start, r_sh_p_min, r_sh_p_dec;
  // Move datapath
  logic [1:0]  r_state;
  logic [31:0] r_p, r_cnt, r_acc, r_rem;
  logic        r_done, r_aborted;
  logic signed [31:0] r_pos;
  // Registered outputs
  logic        r_step, r_fwd, r_irq;
  logic [31:0] r_rdata;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_p_nxt, w_cnt_nxt, w_acc_nxt, w_rem_nxt;
  logic        w_done_nxt, w_aborted_nxt;
  logic [31:0] w_rem_dec, w_acc_inc, w_p_down, w_p_up;
  logic [32:0] w_p_sum;
  logic        w_step_nxt, w_irq_en_nxt, w_irq_nxt;
  logic signed [31:0] w_pos_nxt;
  logic [31:0] w_rdata;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] f_floor(input logic [31:0] v);
    return (v < c_P_FLOOR) ? c_P_FLOOR : v;
  endfunction

  logic w_wr_ctrl, w_wr_status, w_busy, w_start, w_abort;

  assign w_wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 3'd0);
  assign w_wr_status = avs_ctrl_write && (avs_ctrl_address == 3'd5);
  assign w_busy      = (r_state != c_IDLE);
  // Clearing ENABLE mid-move is an abort; ABORT in the START write wins.
  assign w_abort     = w_wr_ctrl && w_busy &&
                       (avs_ctrl_writedata[1] || !avs_ctrl_writedata[3]);
  assign w_start     = w_wr_ctrl && !w_busy && avs_ctrl_writedata[0] &&
                       !avs_ctrl_writedata[1] && avs_ctrl_writedata[3];

  // State register, datapath and output registers
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_dir        <= 1'b0;
      r_enable     <= 1'b0;
      r_irq_en     <= 1'b0;
      r_target     <= '0;
      r_p_start    <= '0;
      r_p_min      <= '0;
      r_p_dec      <= '0;
      r_sh_p_start <= '0;
      r_sh_p_min   <= '0;
      r_sh_p_dec   <= '0;
      r_state      <= c_IDLE;
      r_p          <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_rem        <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_pos        <= '0;
      r_step       <= 1'b0;
      r_fwd        <= 1'b0;
      r_irq        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_dir    <= avs_ctrl_writedata[2];
        r_enable <= avs_ctrl_writedata[3];
        r_irq_en <= avs_ctrl_writedata[4];
      end
      if (avs_ctrl_write) begin
        case (avs_ctrl_address)
          3'd1:    r_target  <= f_merge(r_target,  avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd2:    r_p_start <= f_merge(r_p_start, avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd3:    r_p_min   <= f_merge(r_p_min,   avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd4:    r_p_dec   <= f_merge(r_p_dec,   avs_ctrl_writedata, avs_ctrl_byteenable);
          default: ;
        endcase
      end
      if (w_start) begin
        r_sh_p_start <= f_floor(r_p_start);
        r_sh_p_min   <= f_floor(r_p_min);
        r_sh_p_dec   <= r_p_dec;
        r_fwd        <= avs_ctrl_writedata[2];
      end
      r_state   <= w_state_nxt;
      r_p       <= w_p_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_rem     <= w_rem_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_pos     <= w_pos_nxt;
      r_step    <= w_step_nxt;
      r_irq     <= w_irq_nxt;
      if (avs_ctrl_read) r_rdata <= w_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_p_nxt       = r_p;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_rem_nxt     = r_rem;
    w_done_nxt    = r_done;
    w_aborted_nxt = r_aborted;
    w_rem_dec     = r_rem - 32'd1;
    w_acc_inc     = r_acc + 32'd1;
    w_p_down      = (r_p > r_sh_p_dec) ? (r_p - r_sh_p_dec) : 32'd0;
    w_p_sum       = {1'b0, r_p} + {1'b0, r_sh_p_dec};
    w_p_up        = (w_p_sum > {1'b0, r_sh_p_start}) ? r_sh_p_start : w_p_sum[31:0];

    if (w_wr_status && avs_ctrl_writedata[1]) w_done_nxt = 1'b0;

    if (w_abort) begin
      w_state_nxt   = c_IDLE;
      w_aborted_nxt = 1'b1;
    end else if (w_start) begin
      w_rem_nxt     = r_target;
      w_acc_nxt     = '0;
      w_cnt_nxt     = '0;
      w_p_nxt       = f_floor(r_p_start);
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b0;
      if (r_target == 32'd0) begin
        w_state_nxt = c_IDLE;
        w_done_nxt  = 1'b1;
      end else if (f_floor(r_p_start) <= f_floor(r_p_min)) begin
        w_state_nxt = c_CRUISE;
      end else begin
        w_state_nxt = c_ACCEL;
      end
    end else if (w_busy) begin
      if (r_cnt == r_p - 32'd1) begin
        w_cnt_nxt = '0;
        w_rem_nxt = w_rem_dec;
        if (r_state == c_ACCEL) w_acc_nxt = w_acc_inc;
        if (w_rem_dec == 32'd0) begin
          w_state_nxt = c_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          case (r_state)
            c_ACCEL: begin
              // Decelerate once the remaining steps match those spent speeding up
              if (w_rem_dec <= w_acc_inc) begin
                w_state_nxt = c_DECEL;
              end else if (w_p_down <= r_sh_p_min) begin
                w_state_nxt = c_CRUISE;
                w_p_nxt     = r_sh_p_min;
              end else begin
                w_p_nxt = w_p_down;
              end
            end
            c_CRUISE: begin
              if (w_rem_dec <= r_acc) begin
                w_state_nxt = c_DECEL;
                w_p_nxt     = w_p_up;
              end
            end
            c_DECEL:  w_p_nxt = w_p_up;
            default:  ;
          endcase
        end
      end else begin
        w_cnt_nxt = r_cnt + 32'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    w_step_nxt   = w_busy && !w_abort && (r_cnt < c_PULSE_W);
    w_pos_nxt    = r_pos;
    if (w_step_nxt && (r_cnt == 32'd0)) begin
      w_pos_nxt = r_fwd ? (r_pos + 32'sd1) : (r_pos - 32'sd1);
    end
    w_irq_en_nxt = w_wr_ctrl ? avs_ctrl_writedata[4] : r_irq_en;
    w_irq_nxt    = w_done_nxt && w_irq_en_nxt;
    case (avs_ctrl_address)
      3'd0:    w_rdata = {27'b0, r_irq_en, r_enable, r_dir, 2'b0};
      3'd5:    w_rdata = {28'b0, r_aborted, w_busy, r_done, w_busy};
      3'd6:    w_rdata = r_pos;
      3'd7:    w_rdata = r_rem;
      default: w_rdata = '0;
    endcase
  end

  assign avs_ctrl_readdata    = r_rdata;
  assign avs_ctrl_waitrequest = 1'b0;
  assign step                 = r_step;
  assign forward_back         = r_fwd;
  assign on_off               = r_enable;
  assign irq                  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_step_ramp_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_ramp_generator
// Function : Directed self-checking bench for step_ramp_generator.
// Revision : 1.0
// ============================================================================
module tb_step_ramp_generator;

  localparam int PULSE_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  ben = 4'hF;
  logic [31:0] rdata;
  logic        waitreq, step, fwd, onoff, irq;

  step_ramp_generator #(.PULSE_W(PULSE_W)) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset      (rst),
    .avs_ctrl_address    (addr),
    .avs_ctrl_write      (write),
    .avs_ctrl_writedata  (wdata),
    .avs_ctrl_byteenable (ben),
    .avs_ctrl_read       (read),
    .avs_ctrl_readdata   (rdata),
    .avs_ctrl_waitrequest(waitreq),
    .step                (step),
    .forward_back        (fwd),
    .on_off              (onoff),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rises    = 0;
  int last_rise = 0;
  int high_cnt = 0;
  bit have_last = 1'b0;
  bit prev_step = 1'b0;
  bit width_en  = 1'b1;
  int exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; step edges are scored against the expected-interval queue.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (step && !prev_step) begin
      if (have_last) begin
        if (exp_q.size() == 0) chk("interval_unexpected", cyc - last_rise, 0);
        else                   chk("interval", cyc - last_rise, exp_q.pop_front());
      end
      have_last = 1'b1;
      last_rise = cyc;
      rises++;
      high_cnt  = 0;
    end
    if (!step && prev_step && width_en) chk("pulse_high", high_cnt, PULSE_W);
    if (step) high_cnt++;
    prev_step = step;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    addr = a; wdata = d; ben = be; write = 1'b1;
    tick();
    write = 1'b0; ben = 4'hF;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a; read = 1'b1;
    tick();
    read = 1'b0;
    d = rdata;
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int n;
    n = 0;
    tick();
    while (!irq && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(irq), 1);
  endtask

  task automatic wait_rises(input int base, input int count, input int budget, input string tag);
    int n;
    n = 0;
    while ((rises - base) < count && n < budget) begin
      tick();
      n++;
    end
    chk(tag, rises - base, count);
  endtask

  initial begin
    logic [31:0] d;
    int r0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_step", int'(step), 0);
    chk("rst_fwd", int'(fwd), 0);
    chk("rst_on_off", int'(onoff), 0);
    chk("rst_irq", int'(irq), 0);
    chk("waitrequest", int'(waitreq), 0);
    rd(3'd5, d); chk("rst_status", int'(d), 0);
    rd(3'd6, d); chk("rst_position", int'(d), 0);

    // Full trapezoid, TARGET=10
    wr(3'd2, 32'd100);
    wr(3'd3, 32'd40);
    wr(3'd4, 32'd20);
    wr(3'd1, 32'd10);
    wr(3'd0, 32'h1C);
    chk("on_off_set", int'(onoff), 1);
    rd(3'd0, d); chk("ctrl_read", int'(d), 32'h1C);
    exp_q = '{100, 80, 60, 40, 40, 40, 40, 60, 80};
    have_last = 1'b0; r0 = rises;
    wr(3'd0, 32'h1D);
    rd(3'd5, d); chk("status_busy", int'(d), 5);
    chk("fwd_latched", int'(fwd), 1);
    wait_irq(3000, "t10_irq");
    chk("t10_pulses", rises - r0, 10);
    chk("t10_queue_empty", exp_q.size(), 0);
    rd(3'd6, d); chk("t10_position", int'(d), 10);
    rd(3'd5, d); chk("t10_status_done", int'(d), 2);
    rd(3'd7, d); chk("t10_remaining", int'(d), 0);

    // Triangle, TARGET=4 written through byte lane 0 only
    wr(3'd1, 32'hFFFF_FF04, 4'b0001);
    exp_q = '{100, 80, 80};
    have_last = 1'b0; r0 = rises;
    wr(3'd0, 32'h1D);
    wait_irq(2000, "t4_irq");
    chk("t4_pulses", rises - r0, 4);
    chk("t4_queue_empty", exp_q.size(), 0);
    rd(3'd6, d); chk("t4_position", int'(d), 14);

    // TARGET=6
    wr(3'd1, 32'd6);
    exp_q = '{100, 80, 60, 60, 80};
    have_last = 1'b0; r0 = rises;
    wr(3'd0, 32'h1D);
    wait_irq(2000, "t6_irq");
    chk("t6_pulses", rises - r0, 6);
    chk("t6_queue_empty", exp_q.size(), 0);
    rd(3'd6, d); chk("t6_position", int'(d), 20);

    // Reverse, constant speed; a DIR write mid-move must not reach forward_back
    wr(3'd2, 32'd20);
    wr(3'd3, 32'd20);
    wr(3'd1, 32'd3);
    wr(3'd0, 32'h18);
    exp_q = '{20, 20};
    have_last = 1'b0; r0 = rises;
    wr(3'd0, 32'h19);
    chk("rev_fwd_start", int'(fwd), 0);
    wr(3'd0, 32'h1C);
    repeat (5) tick();
    chk("rev_fwd_mid", int'(fwd), 0);
    wait_irq(500, "rev_irq");
    chk("rev_fwd_end", int'(fwd), 0);
    chk("rev_pulses", rises - r0, 3);
    rd(3'd6, d); chk("rev_position", int'(d), 17);
    rd(3'd0, d); chk("rev_dir_reg", int'(d), 32'h1C);

    // ABORT right after the 5th period of a TARGET=10 move
    wr(3'd2, 32'd100);
    wr(3'd3, 32'd40);
    wr(3'd1, 32'd10);
    exp_q = '{100, 80, 60, 40, 40, 40, 40, 60, 80};
    have_last = 1'b0; r0 = rises;
    wr(3'd0, 32'h1D);
    wait_rises(r0, 5, 2000, "abort_reach5");
    repeat (39) tick();
    wr(3'd0, 32'h1E);
    exp_q.delete();
    repeat (150) tick();
    chk("abort_pulses", rises - r0, 5);
    chk("abort_irq", int'(irq), 0);
    rd(3'd5, d); chk("abort_status", int'(d), 8);
    rd(3'd6, d); chk("abort_position", int'(d), 22);
    rd(3'd7, d); chk("abort_remaining", int'(d), 5);

    // New START accepted, then ENABLE cleared mid-pulse acts as abort
    width_en = 1'b0;
    have_last = 1'b0;
    wr(3'd0, 32'h1D);
    rd(3'd5, d); chk("restart_status", int'(d), 5);
    wr(3'd0, 32'h14);
    repeat (3) tick();
    chk("disable_step", int'(step), 0);
    chk("disable_on_off", int'(onoff), 0);
    rd(3'd5, d); chk("disable_status", int'(d), 8);
    rd(3'd6, d); chk("disable_position", int'(d), 23);
    width_en = 1'b1;

    // TARGET=0: done at once, no pulse
    wr(3'd1, 32'd0);
    r0 = rises;
    wr(3'd0, 32'h1D);
    rd(3'd5, d); chk("t0_status", int'(d), 2);
    chk("t0_irq", int'(irq), 1);
    repeat (20) tick();
    chk("t0_no_pulse", rises - r0, 0);
    wr(3'd5, 32'h2);
    rd(3'd5, d); chk("done_cleared", int'(d), 0);
    chk("irq_cleared", int'(irq), 0);

    // START with ENABLE=0 is ignored
    wr(3'd1, 32'd10);
    wr(3'd0, 32'h11);
    rd(3'd5, d); chk("noen_status", int'(d), 0);
    repeat (20) tick();
    chk("noen_no_pulse", rises - r0, 0);

    // Asynchronous reset while cruising
    wr(3'd0, 32'h1C);
    exp_q = '{100, 80, 60, 40, 40, 40, 40, 60, 80};
    have_last = 1'b0; r0 = rises;
    wr(3'd0, 32'h1D);
    wait_rises(r0, 5, 2000, "rst_reach_cruise");
    rst = 1'b1;
    #1;
    chk("rst_async_step", int'(step), 0);
    chk("rst_async_fwd", int'(fwd), 0);
    chk("rst_async_on_off", int'(onoff), 0);
    prev_step = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    rd(3'd5, d); chk("post_rst_status", int'(d), 0);
    rd(3'd6, d); chk("post_rst_position", int'(d), 0);
    rd(3'd7, d); chk("post_rst_remaining", int'(d), 0);
    rd(3'd0, d); chk("post_rst_ctrl", int'(d), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
